// File: rtl/regfile_fwd_pkg.sv
// Shared FSM encoding and forwarding-record field layout for regfile_fwd.
// Record layout, MSB to LSB: {pend, we, waddr, wdata}.
package regfile_fwd_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    function automatic int rec_w(input int data_w, input int addr_w);
        return data_w + addr_w + 2;
    endfunction

    function automatic int wdata_off(input int data_w, input int addr_w);
        return 0 + 0 * (data_w + addr_w);
    endfunction

    function automatic int waddr_off(input int data_w, input int addr_w);
        return data_w + 0 * addr_w;
    endfunction

    function automatic int we_off(input int data_w, input int addr_w);
        return data_w + addr_w;
    endfunction

    function automatic int pend_off(input int data_w, input int addr_w);
        return data_w + addr_w + 1;
    endfunction

endpackage

// File: rtl/regfile_fwd_sel.sv
// One read port's source selection: youngest matching forward record, then
// same-cycle write-through, then array. Purely combinational.
module regfile_fwd_sel
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NFWD   = 3
) (
    input  logic [ADDR_W-1:0]                         raddr,
    input  logic [NFWD*rec_w(DATA_W, ADDR_W)-1:0]     fwd_bus,
    input  logic                                      we,
    input  logic [ADDR_W-1:0]                         waddr,
    input  logic [DATA_W-1:0]                         wdata,
    input  logic [DATA_W-1:0]                         arr_data,
    output logic [DATA_W-1:0]                         data,
    output logic                                      hazard
);

    localparam int REC_W  = rec_w(DATA_W, ADDR_W);
    localparam int D_OFF  = wdata_off(DATA_W, ADDR_W);
    localparam int A_OFF  = waddr_off(DATA_W, ADDR_W);
    localparam int WE_OFF = we_off(DATA_W, ADDR_W);
    localparam int P_OFF  = pend_off(DATA_W, ADDR_W);

    logic [REC_W-1:0] rec;

    always_comb begin
        data   = arr_data;
        hazard = 1'b0;
        rec    = '0;
        if (we && (waddr == raddr)) begin
            data = wdata;
        end
        // Walk oldest to youngest so the lowest-index match wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            rec = fwd_bus[i*REC_W +: REC_W];
            if (rec[WE_OFF] && (rec[A_OFF +: ADDR_W] == raddr)) begin
                data   = rec[D_OFF +: DATA_W];
                hazard = rec[P_OFF];
            end
        end
        if (raddr == '0) begin
            data   = '0;
            hazard = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_fwd.sv
// Register file with zero-latency forwarded reads, pending-result stall
// detection and a hardware clear sequence after reset.
module regfile_fwd
    import regfile_fwd_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NRD    = 2,
    parameter int NFWD   = 3
) (
    input  logic                                      clk,
    input  logic                                      resetn,
    input  logic [NRD*ADDR_W-1:0]                     raddr,
    output logic [NRD*DATA_W-1:0]                     rdata,
    input  logic [NFWD*rec_w(DATA_W, ADDR_W)-1:0]     fwd_bus,
    input  logic                                      we,
    input  logic [ADDR_W-1:0]                         waddr,
    input  logic [DATA_W-1:0]                         wdata,
    output logic                                      stall,
    output logic                                      ready,
    output logic [15:0]                               hazard_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_t            state;
    logic [ADDR_W-1:0] clr_ptr;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [NRD-1:0]    port_hazard;
    logic              hazard;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            hazard_cnt <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (&clr_ptr) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (hazard && (hazard_cnt != 16'hFFFF)) begin
                        hazard_cnt <= hazard_cnt + 16'd1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Array has no reset of its own; the CLEAR walk zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [DATA_W-1:0] sel_data;

        regfile_fwd_sel #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NFWD   (NFWD)
        ) u_sel (
            .raddr    (raddr[k*ADDR_W +: ADDR_W]),
            .fwd_bus  (fwd_bus),
            .we       (we),
            .waddr    (waddr),
            .wdata    (wdata),
            .arr_data (mem[raddr[k*ADDR_W +: ADDR_W]]),
            .data     (sel_data),
            .hazard   (port_hazard[k])
        );

        assign rdata[k*DATA_W +: DATA_W] = (state == READY) ? sel_data : '0;
    end

    assign hazard = |port_hazard;
    assign ready  = (state == READY);
    assign stall  = (state == CLEAR) || hazard;

endmodule

// File: tb/tb_regfile_fwd.sv
// Directed bench for regfile_fwd: clear sequence, forwarding priority,
// hazard stalls, reset restart and hazard counter saturation.
module tb_regfile_fwd;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NRD    = 2;
    localparam int NFWD   = 3;
    localparam int REC_W  = DATA_W + ADDR_W + 2;

    logic                     clk = 1'b0;
    logic                     resetn;
    logic [NRD*ADDR_W-1:0]    raddr;
    logic [NRD*DATA_W-1:0]    rdata;
    logic [NFWD*REC_W-1:0]    fwd_bus;
    logic                     we;
    logic [ADDR_W-1:0]        waddr;
    logic [DATA_W-1:0]        wdata;
    logic                     stall;
    logic                     ready;
    logic [15:0]              hazard_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_fwd #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD), .NFWD(NFWD)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .raddr      (raddr),
        .rdata      (rdata),
        .fwd_bus    (fwd_bus),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .stall      (stall),
        .ready      (ready),
        .hazard_cnt (hazard_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [REC_W-1:0] mk(input logic p, input logic w,
                                            input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
        return {p, w, a, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        fwd_bus = '0;
    endtask

    task automatic set_fwd(input int i, input logic [REC_W-1:0] r);
        fwd_bus[i*REC_W +: REC_W] = r;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        int s = 0;
        while (!ready && n < 100) begin
            if (stall) s++;
            tick();
            n++;
        end
        n_cmp++;
        if (n !== 32) begin
            n_bad++;
            $display("FAIL %s_cycles got %0d exp 32", name, n);
        end
        n_cmp++;
        if (s !== 32) begin
            n_bad++;
            $display("FAIL %s_stall_cycles got %0d exp 32", name, s);
        end
    endtask

    task automatic test_reset();
        idle();
        resetn = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF_FFFF;
        raddr = {5'd3, 5'd3};
        tick(); tick();
        n_cmp++;
        if ({stall, ready} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_stall_ready got %b exp 10", {stall, ready});
        end
        n_cmp++;
        if (hazard_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_hazard_cnt got %h exp 0000", hazard_cnt);
        end
        n_cmp++;
        if (rdata !== '0) begin
            n_bad++;
            $display("FAIL reset_rdata got %h exp 0", rdata);
        end
        resetn = 1'b1;
        wait_ready("clear");
        idle();
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
            n_bad++;
            $display("FAIL ready_stall got %b exp 0", stall);
        end
    endtask

    task automatic test_cleared();
        for (int a = 1; a < 32; a++) begin
            raddr = {ADDR_W'(32 - a), ADDR_W'(a)};
            #1;
            n_cmp++;
            if (rdata !== '0) begin
                n_bad++;
                $display("FAIL cleared_addr_%0d got %h exp 0", a, rdata);
            end
        end
        idle();
    endtask

    task automatic test_write_through();
        we = 1'b1; waddr = 5'd5; wdata = 32'h1234;
        raddr = {5'd0, 5'd5};
        #1;
        n_cmp++;
        if (rdata[31:0] !== 32'h1234) begin
            n_bad++;
            $display("FAIL wt_same_cycle got %h exp 00001234", rdata[31:0]);
        end
        tick();
        we = 1'b0; waddr = 5'd31; wdata = 32'hCAFE_0031;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if (rdata[31:0] !== 32'h1234) begin
                n_bad++;
                $display("FAIL wt_held_%0d got %h exp 00001234", c, rdata[31:0]);
            end
            tick();
        end
        we = 1'b1; raddr = {5'd31, 5'd5};
        tick();
        we = 1'b0;
        #1;
        n_cmp++;
        if (rdata !== {32'hCAFE_0031, 32'h1234}) begin
            n_bad++;
            $display("FAIL wr_port1 got %h exp cafe003100001234", rdata);
        end
        idle();
    endtask

    task automatic test_fwd_priority();
        set_fwd(0, mk(1'b0, 1'b1, 5'd7, 32'hA));
        set_fwd(2, mk(1'b0, 1'b1, 5'd7, 32'hB));
        raddr = {5'd7, 5'd0};
        #1;
        n_cmp++;
        if ({stall, rdata[63:32]} !== {1'b0, 32'hA}) begin
            n_bad++;
            $display("FAIL fwd_youngest got %b/%h exp 0/0000000a", stall, rdata[63:32]);
        end
        set_fwd(0, '0);
        #1;
        n_cmp++;
        if (rdata[63:32] !== 32'hB) begin
            n_bad++;
            $display("FAIL fwd_oldest got %h exp 0000000b", rdata[63:32]);
        end
        fwd_bus = '0;
        set_fwd(1, mk(1'b0, 1'b1, 5'd5, 32'hC));
        we = 1'b1; waddr = 5'd5; wdata = 32'hD;
        raddr = {5'd0, 5'd5};
        #1;
        n_cmp++;
        if (rdata[31:0] !== 32'hC) begin
            n_bad++;
            $display("FAIL fwd_over_wport got %h exp 0000000c", rdata[31:0]);
        end
        we = 1'b0;
        set_fwd(1, mk(1'b1, 1'b0, 5'd5, 32'hE));
        #1;
        n_cmp++;
        if ({stall, rdata[31:0]} !== {1'b0, 32'h1234}) begin
            n_bad++;
            $display("FAIL fwd_we0_ignored got %b/%h exp 0/00001234", stall, rdata[31:0]);
        end
        set_fwd(0, mk(1'b1, 1'b1, 5'd0, 32'hF));
        raddr = '0;
        #1;
        n_cmp++;
        if ({stall, rdata} !== {1'b0, 64'h0}) begin
            n_bad++;
            $display("FAIL addr0_zero got %b/%h exp 0/0", stall, rdata);
        end
        idle();
    endtask

    task automatic test_hazard();
        set_fwd(1, mk(1'b1, 1'b1, 5'd9, 32'h77));
        raddr = {5'd0, 5'd9};
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({stall, rdata[31:0]} !== {1'b1, 32'h77}) begin
                n_bad++;
                $display("FAIL hazard_cyc_%0d got %b/%h exp 1/00000077", c, stall, rdata[31:0]);
            end
            tick();
        end
        raddr = '0;
        #1;
        n_cmp++;
        if ({stall, hazard_cnt} !== {1'b0, 16'd3}) begin
            n_bad++;
            $display("FAIL hazard_cnt3_raddr0 got %b/%h exp 0/0003", stall, hazard_cnt);
        end
        tick();
        // Combinational-only probes below; inputs return to idle before the next edge.
        fwd_bus = '0;
        set_fwd(0, mk(1'b1, 1'b1, 5'd9, 32'h1));
        set_fwd(2, mk(1'b0, 1'b1, 5'd9, 32'h2));
        raddr = {5'd9, 5'd0};
        #1;
        n_cmp++;
        if ({stall, rdata[63:32]} !== {1'b1, 32'h1}) begin
            n_bad++;
            $display("FAIL pend_shadows got %b/%h exp 1/00000001", stall, rdata[63:32]);
        end
        fwd_bus = '0;
        set_fwd(0, mk(1'b0, 1'b1, 5'd9, 32'h3));
        set_fwd(1, mk(1'b1, 1'b1, 5'd9, 32'h4));
        #1;
        n_cmp++;
        if ({stall, rdata[63:32]} !== {1'b0, 32'h3}) begin
            n_bad++;
            $display("FAIL young_nonpend got %b/%h exp 0/00000003", stall, rdata[63:32]);
        end
        idle();
        #1;
        n_cmp++;
        if (hazard_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL hazard_cnt_hold got %h exp 0003", hazard_cnt);
        end
    endtask

    task automatic test_reset_mid_clear();
        we = 1'b1; waddr = 5'd12; wdata = 32'h5555_AAAA;
        tick();
        idle();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        n_cmp++;
        if ({stall, ready, hazard_cnt} !== {2'b10, 16'd0}) begin
            n_bad++;
            $display("FAIL midclr_state got %b%b/%h exp 10/0000", stall, ready, hazard_cnt);
        end
        wait_ready("restart");
        raddr = {5'd12, 5'd5};
        #1;
        n_cmp++;
        if (rdata !== '0) begin
            n_bad++;
            $display("FAIL contents_cleared got %h exp 0", rdata);
        end
        idle();
    endtask

    task automatic test_saturate();
        set_fwd(1, mk(1'b1, 1'b1, 5'd9, 32'h0));
        raddr = {5'd0, 5'd9};
        repeat (65534) tick();
        n_cmp++;
        if (hazard_cnt !== 16'hFFFE) begin
            n_bad++;
            $display("FAIL sat_pre got %h exp fffe", hazard_cnt);
        end
        repeat (3) tick();
        n_cmp++;
        if (hazard_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hit got %h exp ffff", hazard_cnt);
        end
        tick();
        n_cmp++;
        if (hazard_cnt !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL sat_hold got %h exp ffff", hazard_cnt);
        end
        idle();
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        test_reset();
        test_cleared();
        test_write_through();
        test_fwd_priority();
        test_hazard();
        test_reset_mid_clear();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_fwd.md
REGFILE_FWD -- requirements
Module: regfile_fwd

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth is 2^ADDR_W entries.
REQ-003 Parameter NRD, default 2, SHALL set the number of read ports.
REQ-004 Parameter NFWD, default 3, SHALL set the number of forwarding sources; index 0 is the youngest stage.
REQ-005 Port clk  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-006 Port resetn  in  1  SHALL be a synchronous, active-low reset.
REQ-007 Port raddr  in  NRD*ADDR_W  SHALL carry the read addresses; port k occupies slice k.
REQ-008 Port rdata  out  NRD*DATA_W  SHALL carry the read data; port k occupies slice k.
REQ-009 Port fwd_bus  in  NFWD*(DATA_W+ADDR_W+2)  SHALL carry one record per source, packed as {pend, we, waddr, wdata} with source 0 in the LSB slice.
REQ-010 Port we  in  1  SHALL be the write-back enable.
REQ-011 Port waddr  in  ADDR_W  SHALL be the write-back address.
REQ-012 Port wdata  in  DATA_W  SHALL be the write-back data.
REQ-013 Port stall  out  1  SHALL request a pipeline stall.
REQ-014 Port ready  out  1  SHALL be high only in state READY.
REQ-015 Port hazard_cnt  out  16  SHALL hold a saturating count of hazard stall cycles.

Function
REQ-016 The FSM SHALL have exactly two states: CLEAR and READY.
REQ-017 In CLEAR, entry clr_ptr SHALL be written with 0 each cycle, and clr_ptr SHALL increment by 1 each cycle.
REQ-018 CLEAR SHALL go to READY on the cycle that writes entry 2^ADDR_W-1, so clearing takes 2^ADDR_W cycles.
REQ-019 In CLEAR: stall=1, ready=0, every rdata slice=0, and we is ignored.
REQ-020 In READY, a write SHALL occur at the clock edge when we=1 and waddr!=0; entry 0 SHALL never be written.
REQ-021 Address 0 SHALL always read 0, whatever any forwarding record contains.
REQ-022 Read port k SHALL return data in this priority order: lowest-index fwd source with we=1 and waddr==raddr; then the write port (we=1, waddr==raddr, same-cycle write-through); then the array.
REQ-023 The read path SHALL be purely combinational, with zero-cycle latency.
REQ-024 hazard SHALL be 1 when, for any read port with raddr!=0, the selected fwd record has pend=1; rdata then carries that record's wdata.
REQ-025 A pend=1 record SHALL shadow any older match; an older non-pending match SHALL NOT clear the hazard.
REQ-026 In READY, stall SHALL equal hazard.
REQ-027 hazard_cnt SHALL increment on each READY cycle with hazard=1, SHALL saturate at 16'hFFFF, and SHALL hold otherwise.
REQ-028 A read and a write to the same address in the same cycle SHALL return the new wdata, and the array SHALL update at the edge.

Reset
REQ-029 When resetn=0 at a clock edge: state=CLEAR, clr_ptr=0, hazard_cnt=0.
REQ-030 Outputs during and after reset SHALL be: stall=1, ready=0, rdata=0, until CLEAR completes.
REQ-031 Reset asserted during CLEAR SHALL restart clearing from entry 0.
REQ-032 Reset asserted during READY SHALL start a full clear; no array contents survive reset.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding (CLEAR=1'b0, READY=1'b1) and the fwd record field offsets as functions of DATA_W and ADDR_W.
REQ-034 Per-port selection SHALL be one sub-module, regfile_fwd_sel, instantiated NRD times; it SHALL output data and hazard for one port.

Verification
REQ-035 Release reset: stall=1 for exactly 32 cycles, then ready=1; reading any of addresses 1..31 returns 0.
REQ-036 we=1, waddr=5, wdata=32'h1234 while raddr0=5 in the same cycle -> rdata0=32'h1234 that cycle and every following cycle.
REQ-037 fwd0={0,1,7,32'hA}, fwd2={0,1,7,32'hB}, raddr1=7 -> rdata1=32'hA, stall=0.
REQ-038 fwd1={1,1,9,x}, raddr0=9 held for 3 cycles -> stall=1 each cycle, hazard_cnt=3; the same record with raddr=0 -> stall=0.
REQ-039 Assert resetn=0 at clear cycle 10 -> clearing restarts; ready rises 32 cycles after release; hazard_cnt=0.
REQ-040 Force hazard_cnt to 16'hFFFE, then hold a hazard for 3 cycles -> hazard_cnt=16'hFFFF and stays there.
